// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit, signed and unsigned.
// One operand bit is processed per RUN cycle: shift-add for multiply,
// restoring shift-subtract for divide. Sign handling is done on magnitudes
// in PREP and undone in FIX.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [2:0] {IDLE, PREP, RUN, FIX, DONE} state_t;

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] mag_b_q, mag_b_d;
    // rem_q is the product upper half / running remainder,
    // quo_q is the multiplier being shifted out / quotient being shifted in.
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             dz_q, dz_d;

    // Operand decode and per-step datapath, shared by PREP/RUN/FIX.
    logic               is_signed, is_div;
    logic               sign_a, sign_b;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_diff;
    logic               div_fits;
    logic [2*WIDTH-1:0] product, product_fix;

    assign is_signed   = ~op_q[0];
    assign is_div      = op_q[1];
    assign sign_a      = is_signed & a_q[WIDTH-1];
    assign sign_b      = is_signed & b_q[WIDTH-1];
    assign mag_a       = sign_a ? -a_q : a_q;
    assign mag_b       = sign_b ? -b_q : b_q;
    assign mul_sum     = {1'b0, rem_q} + (quo_q[0] ? {1'b0, mag_b_q} : '0);
    assign div_shift   = {rem_q, quo_q[WIDTH-1]};
    assign div_fits    = div_shift >= {1'b0, mag_b_q};
    // The remainder after a successful subtract is below the divisor, so the
    // low WIDTH bits of the shifted value are enough to form it.
    assign div_diff    = div_shift[WIDTH-1:0] - mag_b_q;
    assign product     = {rem_q, quo_q};
    assign product_fix = neg_res_q ? -product : product;

    // Next-state and datapath update for the five-state sequencer.
    always_comb begin
        // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latches).
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        mag_b_d   = mag_b_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        cnt_d     = cnt_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        dz_d      = dz_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    op_d    = op;
                    a_d     = a;
                    b_d     = b;
                    state_d = PREP;
                end
            end
            PREP: begin
                neg_res_d = sign_a ^ sign_b;
                neg_rem_d = sign_a;
                mag_b_d   = mag_b;
                rem_d     = '0;
                quo_d     = mag_a;
                cnt_d     = '0;
                if (is_div && (b_q == '0)) begin
                    hi_d    = a_q;
                    lo_d    = '1;
                    dz_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            RUN: begin
                cnt_d = cnt_q + CW'(1);
                if (is_div) begin
                    rem_d = div_fits ? div_diff : div_shift[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], div_fits};
                end else begin
                    rem_d = mul_sum[WIDTH:1];
                    quo_d = {mul_sum[0], quo_q[WIDTH-1:1]};
                end
                if (cnt_q == LAST_STEP) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (is_div) begin
                    lo_d = neg_res_q ? -quo_q : quo_q;
                    hi_d = neg_rem_q ? -rem_q : rem_q;
                end else begin
                    {hi_d, lo_d} = product_fix;
                end
                dz_d    = 1'b0;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            mag_b_q   <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            cnt_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            dz_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            mag_b_q   <= mag_b_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            cnt_q     <= cnt_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            dz_q      <= dz_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign div_zero = dz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit at WIDTH = 32.
module tb_mult_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_zero;

    int checks;
    int errors;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launch one operation and follow it to its done pulse.
    // lat = rising edges from the start edge to the edge after which done is seen.
    // Inputs are scrambled right after the start edge to prove they were captured.
    // inject_at > 0 pulses start with other operands at edge k+inject_at.
    // start_in_done raises start during the DONE cycle.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input int inject_at, input bit start_in_done,
                          output logic [31:0] r_hi, output logic [31:0] r_lo,
                          output logic r_dz, output int lat,
                          output bit busy_ok, output bit pulse_ok);
        int n;
        @(negedge clk);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = ~x;
        b     = ~y;
        op    = ~o;
        lat     = -1;
        busy_ok = 1'b1;
        n       = 0;
        while (n < 100) begin
            @(negedge clk);
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (done === 1'b1) begin
                lat = n;
                break;
            end
            if (inject_at > 0 && n == inject_at - 1) begin
                start = 1'b1;
                a     = 32'h0000_1234;
                b     = 32'h0000_0005;
                op    = OP_MULTU;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            n++;
        end
        r_hi = hi;
        r_lo = lo;
        r_dz = div_zero;
        if (start_in_done) start = 1'b1;
        @(negedge clk);
        pulse_ok = (lat >= 0) && (done === 1'b0) && (busy === 1'b0);
        start = 1'b0;
        @(negedge clk);
        pulse_ok = pulse_ok && (busy === 1'b0) && (done === 1'b0) &&
                   (hi === r_hi) && (lo === r_lo);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl busy=%b done=%b expected busy=0 done=0", busy, done);
        end
        checks++;
        if (hi !== 32'h0 || lo !== 32'h0 || div_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_data hi=%h lo=%h dz=%b expected 0/0/0", hi, lo, div_zero);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_start busy=%b expected 0", busy);
        end
    endtask

    task automatic test_multu_max();
        logic [31:0] r_hi, r_lo;
        logic        r_dz;
        int          lat;
        bit          busy_ok, pulse_ok;
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, r_hi, r_lo, r_dz, lat, busy_ok, pulse_ok);
        checks++;
        if (r_hi !== 32'hFFFF_FFFE || r_lo !== 32'h0000_0001) begin
            errors++;
            $display("FAIL multu_max got=%h_%h expected fffffffe_00000001", r_hi, r_lo);
        end
        checks++;
        if (lat != 34) begin
            errors++;
            $display("FAIL multu_latency got=%0d expected 34", lat);
        end
        checks++;
        if (!busy_ok) begin
            errors++;
            $display("FAIL multu_busy got=dropped expected=high throughout");
        end
        checks++;
        if (!pulse_ok) begin
            errors++;
            $display("FAIL multu_done_pulse got=not_one_cycle_or_unstable expected=one_cycle_pulse");
        end
    endtask

    task automatic test_mult_signed();
        logic [31:0] r_hi, r_lo;
        logic        r_dz;
        int          lat;
        bit          busy_ok, pulse_ok;
        run_op(OP_MULT, 32'hFFFF_FFFD, 32'h0000_0005, 0, 1'b0, r_hi, r_lo, r_dz, lat, busy_ok, pulse_ok);
        checks++;
        if (r_hi !== 32'hFFFF_FFFF || r_lo !== 32'hFFFF_FFF1 || r_dz !== 1'b0) begin
            errors++;
            $display("FAIL mult_neg got=%h_%h dz=%b expected ffffffff_fffffff1 dz=0", r_hi, r_lo, r_dz);
        end
        run_op(OP_MULT, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 0, 1'b0, r_hi, r_lo, r_dz, lat, busy_ok, pulse_ok);
        checks++;
        if (r_hi !== 32'h0 || r_lo !== 32'h0000_000F) begin
            errors++;
            $display("FAIL mult_negneg got=%h_%h expected 00000000_0000000f", r_hi, r_lo);
        end
    endtask

    task automatic test_divide();
        logic [31:0] r_hi, r_lo;
        logic        r_dz;
        int          lat;
        bit          busy_ok, pulse_ok;
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 0, 1'b0, r_hi, r_lo, r_dz, lat, busy_ok, pulse_ok);
        checks++;
        if (r_lo !== 32'hFFFF_FFFD || r_hi !== 32'hFFFF_FFFF || r_dz !== 1'b0) begin
            errors++;
            $display("FAIL div_neg_dividend got q=%h r=%h dz=%b expected q=fffffffd r=ffffffff dz=0", r_lo, r_hi, r_dz);
        end
        checks++;
        if (lat != 34) begin
            errors++;
            $display("FAIL div_latency got=%0d expected 34", lat);
        end
        run_op(OP_DIVU, 32'hFFFF_FFF9, 32'h0000_0002, 0, 1'b0, r_hi, r_lo, r_dz, lat, busy_ok, pulse_ok);
        checks++;
        if (r_lo !== 32'h7FFF_FFFC || r_hi !== 32'h0000_0001) begin
            errors++;
            $display("FAIL divu got q=%h r=%h expected q=7ffffffc r=00000001", r_lo, r_hi);
        end
        run_op(OP_DIV, 32'h0000_0007, 32'hFFFF_FFFE, 0, 1'b0, r_hi, r_lo, r_dz, lat, busy_ok, pulse_ok);
        checks++;
        if (r_lo !== 32'hFFFF_FFFD || r_hi !== 32'h0000_0001) begin
            errors++;
            $display("FAIL div_neg_divisor got q=%h r=%h expected q=fffffffd r=00000001", r_lo, r_hi);
        end
    endtask

    task automatic test_div_zero();
        logic [31:0] r_hi, r_lo;
        logic        r_dz;
        int          lat;
        bit          busy_ok, pulse_ok;
        run_op(OP_DIVU, 32'h0000_0064, 32'h0, 0, 1'b0, r_hi, r_lo, r_dz, lat, busy_ok, pulse_ok);
        checks++;
        if (r_dz !== 1'b1 || r_hi !== 32'h0000_0064 || r_lo !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL divzero_result got hi=%h lo=%h dz=%b expected hi=00000064 lo=ffffffff dz=1", r_hi, r_lo, r_dz);
        end
        checks++;
        if (lat != 1) begin
            errors++;
            $display("FAIL divzero_latency got=%0d expected 1", lat);
        end
        checks++;
        if (!pulse_ok) begin
            errors++;
            $display("FAIL divzero_pulse got=bad expected=one_cycle_pulse");
        end
        run_op(OP_MULTU, 32'h0000_0002, 32'h0000_0003, 0, 1'b0, r_hi, r_lo, r_dz, lat, busy_ok, pulse_ok);
        checks++;
        if (r_lo !== 32'h0000_0006 || r_hi !== 32'h0 || r_dz !== 1'b0) begin
            errors++;
            $display("FAIL divzero_clear got hi=%h lo=%h dz=%b expected hi=0 lo=6 dz=0", r_hi, r_lo, r_dz);
        end
    endtask

    task automatic test_overflow_ignore_start();
        logic [31:0] r_hi, r_lo;
        logic        r_dz;
        int          lat;
        bit          busy_ok, pulse_ok;
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 1'b1, r_hi, r_lo, r_dz, lat, busy_ok, pulse_ok);
        checks++;
        if (r_lo !== 32'h8000_0000 || r_hi !== 32'h0 || r_dz !== 1'b0) begin
            errors++;
            $display("FAIL div_overflow got q=%h r=%h dz=%b expected q=80000000 r=0 dz=0", r_lo, r_hi, r_dz);
        end
        checks++;
        if (lat != 34) begin
            errors++;
            $display("FAIL busy_start_latency got=%0d expected 34", lat);
        end
        checks++;
        if (!pulse_ok) begin
            errors++;
            $display("FAIL done_cycle_start got=accepted_or_bad_pulse expected=ignored");
        end
    endtask

    task automatic test_reset_mid_run();
        logic [31:0] r_hi, r_lo;
        logic        r_dz;
        int          lat;
        bit          busy_ok, pulse_ok;
        bit          saw_done;
        @(negedge clk);
        op    = OP_MULTU;
        a     = 32'h0000_0009;
        b     = 32'h0000_0009;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            errors++;
            $display("FAIL reset_abort got busy=%b done=%b hi=%h lo=%h expected 0/0/0/0", busy, done, hi, lo);
        end
        saw_done = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (done !== 1'b0) saw_done = 1'b1;
        end
        reset = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL reset_no_done got=activity expected=idle_after_abort");
        end
        run_op(OP_MULTU, 32'h0000_0007, 32'h0000_0006, 0, 1'b0, r_hi, r_lo, r_dz, lat, busy_ok, pulse_ok);
        checks++;
        if (r_lo !== 32'd42 || r_hi !== 32'h0) begin
            errors++;
            $display("FAIL post_reset_mult got=%h_%h expected 00000000_0000002a", r_hi, r_lo);
        end
        checks++;
        if (lat != 34) begin
            errors++;
            $display("FAIL post_reset_latency got=%0d expected 34", lat);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_multu_max();
        test_mult_signed();
        test_divide();
        test_div_zero();
        test_overflow_ignore_start();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 32, operand width in bits; legal values are 4 to 64.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state changes occur on the rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-004 The block SHALL have port start, input, 1 bit: request a new operation; sampled only in IDLE.
REQ-005 The block SHALL have port op, input, 2 bits: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
REQ-006 The block SHALL have port a, input, WIDTH bits: multiplicand or dividend.
REQ-007 The block SHALL have port b, input, WIDTH bits: multiplier or divisor.
REQ-008 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse; hi, lo and div_zero are valid while it is high.
REQ-010 The block SHALL have port hi, output, WIDTH bits: product upper half, or remainder.
REQ-011 The block SHALL have port lo, output, WIDTH bits: product lower half, or quotient.
REQ-012 The block SHALL have port div_zero, output, 1 bit: the last completed operation was a division with b == 0.

Function
REQ-013 The block SHALL use exactly these states: IDLE, PREP, RUN, FIX and DONE.
REQ-014 IDLE SHALL move to PREP on a rising edge with start = 1; a, b and op are captured at that edge, so later changes to the inputs have no effect.
REQ-015 In IDLE with start = 0, the block SHALL stay in IDLE.
REQ-016 While busy = 1, start SHALL be ignored: no queuing, no restart, no corruption of the operation in progress.
REQ-017 PREP SHALL form the magnitudes of the captured operands for signed ops (unsigned ops pass through) and record the result signs, then move to RUN with the iteration counter set to 0.
REQ-018 RUN SHALL perform one radix-2 step per cycle for exactly WIDTH cycles: shift-add for multiply, restoring shift-subtract for divide. It then moves to FIX.
REQ-019 FIX SHALL apply two's-complement sign correction:
- product negated when the operand signs differ;
- quotient negated when the operand signs differ;
- remainder takes the dividend's sign.
FIX then registers hi/lo and moves to DONE.
REQ-020 DONE SHALL drive done = 1 for exactly one cycle, then return to IDLE; a start in the DONE cycle is ignored.
REQ-021 Latency: if start is sampled at edge k, done SHALL be high in the cycle following edge k+WIDTH+2 (edge k+34 for WIDTH = 32).
REQ-022 Multiply results SHALL be full 2*WIDTH bits, with hi = bits [2W-1:W] and lo = bits [W-1:0].
REQ-023 Signed division SHALL truncate the quotient toward zero.
REQ-024 Division with b == 0 (op 10 or 11) SHALL go from PREP straight to DONE with hi = a, lo = all ones and div_zero = 1; done is high in the cycle after edge k+1.
REQ-025 Signed overflow (DIV of the most-negative value by -1) SHALL produce lo = most-negative value and hi = 0, with no flag.
REQ-026 hi, lo and div_zero SHALL change only on entry to DONE, and hold their values until the next entry to DONE.
REQ-027 div_zero SHALL be cleared by any completion that is not a divide-by-zero.

Reset
REQ-028 reset = 0 SHALL immediately force state IDLE and busy = 0, done = 0, div_zero = 0, hi = 0, lo = 0, counter = 0, independent of clk.
REQ-029 Reset asserted mid-operation SHALL abort the operation with no done pulse; the first start after reset is released gets the full latency.

Verification
REQ-030 MULTU a = 0xFFFFFFFF, b = 0xFFFFFFFF -> hi = 0xFFFFFFFE, lo = 0x00000001; done exactly 34 edges after the start edge; busy high throughout.
REQ-031 MULT a = 0xFFFFFFFD (-3), b = 5 -> hi = 0xFFFFFFFF, lo = 0xFFFFFFF1; div_zero = 0.
REQ-032 DIV a = 0xFFFFFFF9 (-7), b = 2 -> lo = 0xFFFFFFFD (-3), hi = 0xFFFFFFFF (-1). DIVU with the same operands -> lo = 0x7FFFFFFC, hi = 1.
REQ-033 DIVU a = 0x64, b = 0 -> done after edge k+1 with div_zero = 1, hi = 0x64, lo = 0xFFFFFFFF. A following MULTU 2*3 -> lo = 6 and div_zero = 0.
REQ-034 DIV a = 0x80000000, b = 0xFFFFFFFF -> lo = 0x80000000, hi = 0. Pulsing start with new operands at edge k+10 changes neither the result nor the timing.
REQ-035 Assert reset = 0 midway through RUN (between edges) -> busy = 0, hi = lo = 0 immediately, and no done pulse. After release, MULTU 7*6 -> lo = 42 at the full 34-edge latency.
